run_monitor: RTL

Downstream observer for the ones-counter/control-unit stage. Watches the stage's start strobe `s`, its serial input `x`, and its registered done flag `g`. Measures each run's latency (start to done) and its stall cycles (`x` low while running), and counts completed runs. Each result is presented as a one-entry valid/ready record to the lab-test reporting logic.

---
 rtl/run_monitor_pkg.sv | 13 +
 rtl/run_monitor_sat_counter.sv | 27 ++
 rtl/run_monitor.sv | 114 +++++++++++
 3 files changed

// File: rtl/run_monitor_pkg.sv
// Shared types and default widths for the run monitor.
// Imported by the monitor top level.
package run_monitor_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int LAT_W_DEF = 8;
  localparam int RUN_W_DEF = 8;

endpackage

// File: rtl/run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/run_monitor.sv
// Observes start/done of the ones-counter stage, measures latency and stalls
// per run, and offers each result as a single-entry valid/ready record.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF,
  parameter int RUN_W = RUN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic             x,
  input  logic             g,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [LAT_W-1:0] rec_latency,
  output logic [LAT_W-1:0] rec_stalls,
  output logic [RUN_W-1:0] run_count,
  output logic             busy,
  output logic             overflow,
  output logic             spurious
);

  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  state_t state_reg, state_next;
  logic   start, done;
  logic   lat_en, stall_en;

  logic [LAT_W-1:0] lat_cnt, stall_cnt, final_lat;

  logic             rec_valid_reg;
  logic [LAT_W-1:0] rec_latency_reg, rec_stalls_reg;
  logic [RUN_W-1:0] run_count_reg;
  logic             overflow_reg, spurious_reg;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: if (s) begin
        state_next = ST_RUN;
        start      = 1'b1;
      end
      ST_RUN: if (g) begin
        state_next = ST_IDLE;
        done       = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The done edge contributes one latency edge but never a stall edge.
  assign lat_en   = (state_reg == ST_RUN) && !g;
  assign stall_en = lat_en && !x;

  sat_counter #(.W(LAT_W)) u_lat (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .en    (lat_en),
    .count (lat_cnt)
  );

  sat_counter #(.W(LAT_W)) u_stall (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .en    (stall_en),
    .count (stall_cnt)
  );

  assign final_lat = (lat_cnt == LAT_MAX) ? lat_cnt : lat_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rec_valid_reg   <= 1'b0;
      rec_latency_reg <= '0;
      rec_stalls_reg  <= '0;
      run_count_reg   <= '0;
      overflow_reg    <= 1'b0;
      spurious_reg    <= 1'b0;
    end else begin
      if (done) begin
        run_count_reg <= run_count_reg + 1'b1;
        if (!rec_valid_reg || rec_ready) begin
          rec_valid_reg   <= 1'b1;
          rec_latency_reg <= final_lat;
          rec_stalls_reg  <= stall_cnt;
        end else begin
          overflow_reg <= 1'b1;
        end
      end else if (rec_valid_reg && rec_ready) begin
        rec_valid_reg <= 1'b0;
      end
      if ((state_reg == ST_IDLE) && g) spurious_reg <= 1'b1;
    end
  end

  assign rec_valid   = rec_valid_reg;
  assign rec_latency = rec_latency_reg;
  assign rec_stalls  = rec_stalls_reg;
  assign run_count   = run_count_reg;
  assign busy        = (state_reg == ST_RUN);
  assign overflow    = overflow_reg;
  assign spurious    = spurious_reg;

endmodule
